// File: rtl/rs_issue_sched.sv
// rs_issue_sched: issue scheduler for the 8-entry ALU reservation station.
//
// Holds only tags and status for each entry. Operand payloads are stored elsewhere.
// The block applies CDB wakeups and keeps an age matrix. Each cycle it picks the
// oldest READY entry and places it in an issue register, which feeds the ALU
// over a valid/ready handshake.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   alloc{0,1}_*               dispatch writes; slot 1 is younger than slot 0
//   wb_valid, wb_tag           CDB broadcast used for wakeup
//   flush                      synchronous squash of every entry
//   issue_valid/idx/ready      selected entry handshake towards the ALU
//   entry_busy, free_count     occupancy, sent to the free-slot finder and stall logic
//
// Optional macro RS_ISSUE_PERF_EN adds two outputs:
//   perf_issued  counts issue handshakes
//   perf_stall   counts cycles with issue_valid && !issue_ready
// Both counters are cleared by reset only. A flush does not clear them.

// Per-entry status: tags, ready bits and the FREE/WAIT/READY/PICKED FSM.
module rs_issue_entry #(
  parameter int TAG_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             alloc_i,
  input  logic [TAG_W-1:0] src1_tag_i,
  input  logic [TAG_W-1:0] src2_tag_i,
  input  logic             src1_rdy_i,
  input  logic             src2_rdy_i,
  input  logic             wb_valid_i,
  input  logic [TAG_W-1:0] wb_tag_i,
  input  logic             pick_i,
  input  logic             done_i,
  output logic             busy_o,
  output logic             busy_d_o,
  output logic             ready_o
);
  typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY, S_PICKED} state_e;

  state_e           state_q, state_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d;
  logic             rdy1_q, rdy1_d, rdy2_q, rdy2_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FREE;
      tag1_q  <= '0;
      tag2_q  <= '0;
      rdy1_q  <= 1'b0;
      rdy2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tag1_d  = tag1_q;
    tag2_d  = tag2_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    case (state_q)
      S_FREE: if (alloc_i) begin
        tag1_d  = src1_tag_i;
        tag2_d  = src2_tag_i;
        // Bypass: a broadcast in the alloc cycle counts as already available.
        rdy1_d  = src1_rdy_i | (wb_valid_i && (wb_tag_i == src1_tag_i));
        rdy2_d  = src2_rdy_i | (wb_valid_i && (wb_tag_i == src2_tag_i));
        state_d = (rdy1_d && rdy2_d) ? S_READY : S_WAIT;
      end
      S_WAIT: begin
        rdy1_d = rdy1_q | (wb_valid_i && (wb_tag_i == tag1_q));
        rdy2_d = rdy2_q | (wb_valid_i && (wb_tag_i == tag2_q));
        if (rdy1_d && rdy2_d) state_d = S_READY;
      end
      S_READY:  if (pick_i) state_d = S_PICKED;
      S_PICKED: if (done_i) state_d = S_FREE;
      default:  state_d = S_FREE;
    endcase
    if (flush_i) state_d = S_FREE;
  end

  assign busy_o   = (state_q != S_FREE);
  assign busy_d_o = (state_d != S_FREE);
  assign ready_o  = (state_q == S_READY);
endmodule

module rs_issue_sched #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int TAG_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc0_valid,
  input  logic [IDX_W-1:0] alloc0_idx,
  input  logic [TAG_W-1:0] alloc0_src1_tag,
  input  logic [TAG_W-1:0] alloc0_src2_tag,
  input  logic             alloc0_src1_rdy,
  input  logic             alloc0_src2_rdy,
  input  logic             alloc1_valid,
  input  logic [IDX_W-1:0] alloc1_idx,
  input  logic [TAG_W-1:0] alloc1_src1_tag,
  input  logic [TAG_W-1:0] alloc1_src2_tag,
  input  logic             alloc1_src1_rdy,
  input  logic             alloc1_src2_rdy,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic             flush,
  output logic             issue_valid,
  output logic [IDX_W-1:0] issue_idx,
  input  logic             issue_ready,
  output logic [DEPTH-1:0] entry_busy,
`ifdef RS_ISSUE_PERF_EN
  output logic [IDX_W:0]   free_count,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall
`else
  output logic [IDX_W:0]   free_count
`endif
);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]            alloc_vec, pick_vec, done_vec;
  logic [DEPTH-1:0]            busy, busy_d, ready, blk, cand;
  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;  // [j][i]: j is older than i
  logic [IDX_W-1:0]            cand_idx, issue_idx_q, issue_idx_d;
  logic                        issue_valid_q, issue_valid_d;
  logic [CNT_W-1:0]            free_count_q, free_count_d;
  logic                        hs, load;

  assign hs   = issue_valid_q && issue_ready;
  assign load = (!issue_valid_q || issue_ready) && (|cand) && !flush;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic sel0, sel1;
    assign sel0         = alloc0_valid && (alloc0_idx == IDX_W'(g));
    assign sel1         = alloc1_valid && (alloc1_idx == IDX_W'(g));
    assign alloc_vec[g] = sel0 | sel1;
    assign pick_vec[g]  = load && cand[g];
    assign done_vec[g]  = hs && (issue_idx_q == IDX_W'(g));

    rs_issue_entry #(.TAG_W(TAG_W)) u_ent (
      .clk        (clk),
      .reset      (reset),
      .flush_i    (flush),
      .alloc_i    (alloc_vec[g]),
      .src1_tag_i (sel1 ? alloc1_src1_tag : alloc0_src1_tag),
      .src2_tag_i (sel1 ? alloc1_src2_tag : alloc0_src2_tag),
      .src1_rdy_i (sel1 ? alloc1_src1_rdy : alloc0_src1_rdy),
      .src2_rdy_i (sel1 ? alloc1_src2_rdy : alloc0_src2_rdy),
      .wb_valid_i (wb_valid),
      .wb_tag_i   (wb_tag),
      .pick_i     (pick_vec[g]),
      .done_i     (done_vec[g]),
      .busy_o     (busy[g]),
      .busy_d_o   (busy_d[g]),
      .ready_o    (ready[g])
    );
  end

  // Age matrix. A new entry is younger than every entry already busy, so its
  // column copies the busy vector and its row is cleared. In a dual alloc,
  // slot 0 is treated as older than slot 1.
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (alloc_vec[i])
          older_d[j][i] = busy[j] | (alloc0_valid && alloc1_valid &&
                                     (alloc0_idx == IDX_W'(j)) && (alloc1_idx == IDX_W'(i)));
        else if (alloc_vec[j])
          older_d[j][i] = 1'b0;
      end
    end
    if (flush) older_d = '0;
  end

  // Oldest-ready select. Ages form a total order, so cand is at most one-hot,
  // and an OR-reduce encodes it into an index.
  always_comb begin
    blk      = '0;
    cand     = '0;
    cand_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        blk[i] = blk[i] | (older_q[j][i] & ready[j]);
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = ready[i] & ~blk[i];
      if (cand[i]) cand_idx = cand_idx | IDX_W'(i);
    end
  end

  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_idx_d   = issue_idx_q;
    if (flush) begin
      issue_valid_d = 1'b0;
    end else if (!issue_valid_q || issue_ready) begin
      issue_valid_d = |cand;
      if (|cand) issue_idx_d = cand_idx;
    end
  end

  // Counted from next-state busy so that the registered value matches entry_busy.
  always_comb begin
    free_count_d = '0;
    for (int i = 0; i < DEPTH; i++)
      free_count_d = free_count_d + {{IDX_W{1'b0}}, ~busy_d[i]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      older_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
      free_count_q  <= CNT_W'(DEPTH);
    end else begin
      older_q       <= older_d;
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
      free_count_q  <= free_count_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_idx   = issue_idx_q;
  assign entry_busy  = busy;
  assign free_count  = free_count_q;

`ifdef RS_ISSUE_PERF_EN
  logic [31:0] perf_issued_q, perf_stall_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (hs && !flush)                 perf_issued_q <= perf_issued_q + 32'd1;
      if (issue_valid_q && !issue_ready) perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end
  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

`ifndef SYNTHESIS
  a_alloc0_free: assert property (@(posedge clk) disable iff (reset)
    alloc0_valid |-> !busy[alloc0_idx]);
  a_alloc1_free: assert property (@(posedge clk) disable iff (reset)
    alloc1_valid |-> !busy[alloc1_idx]);
  a_alloc_dup: assert property (@(posedge clk) disable iff (reset)
    (alloc0_valid && alloc1_valid) |-> (alloc0_idx != alloc1_idx));
  a_cand_1hot: assert property (@(posedge clk) disable iff (reset) $onehot0(cand));
`endif
endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed bench for rs_issue_sched. The stimulus pushes the expected issue
// order into exp_q. A negedge monitor pops one expected index for every issue
// handshake and compares it. Occupancy and latency are checked inline.
module tb_rs_issue_sched;
  logic       clk, reset;
  logic       alloc0_valid, alloc0_src1_rdy, alloc0_src2_rdy;
  logic [2:0] alloc0_idx;
  logic [6:0] alloc0_src1_tag, alloc0_src2_tag;
  logic       alloc1_valid, alloc1_src1_rdy, alloc1_src2_rdy;
  logic [2:0] alloc1_idx;
  logic [6:0] alloc1_src1_tag, alloc1_src2_tag;
  logic       wb_valid, flush, issue_valid, issue_ready;
  logic [6:0] wb_tag;
  logic [2:0] issue_idx;
  logic [7:0] entry_busy;
  logic [3:0] free_count;
`ifdef RS_ISSUE_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  rs_issue_sched dut (
    .clk(clk), .reset(reset),
    .alloc0_valid(alloc0_valid), .alloc0_idx(alloc0_idx),
    .alloc0_src1_tag(alloc0_src1_tag), .alloc0_src2_tag(alloc0_src2_tag),
    .alloc0_src1_rdy(alloc0_src1_rdy), .alloc0_src2_rdy(alloc0_src2_rdy),
    .alloc1_valid(alloc1_valid), .alloc1_idx(alloc1_idx),
    .alloc1_src1_tag(alloc1_src1_tag), .alloc1_src2_tag(alloc1_src2_tag),
    .alloc1_src1_rdy(alloc1_src1_rdy), .alloc1_src2_rdy(alloc1_src2_rdy),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .flush(flush),
    .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_ready(issue_ready),
    .entry_busy(entry_busy),
    .free_count(free_count)
`ifdef RS_ISSUE_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic clr();
    alloc0_valid = 0; alloc0_idx = 0; alloc0_src1_tag = 0; alloc0_src2_tag = 0;
    alloc0_src1_rdy = 0; alloc0_src2_rdy = 0;
    alloc1_valid = 0; alloc1_idx = 0; alloc1_src1_tag = 0; alloc1_src2_tag = 0;
    alloc1_src1_rdy = 0; alloc1_src2_rdy = 0;
    wb_valid = 0; wb_tag = 0; flush = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    clr();
  endtask

  task automatic al0(input int idx, input int t1, input bit r1, input int t2, input bit r2);
    alloc0_valid = 1; alloc0_idx = idx[2:0];
    alloc0_src1_tag = t1[6:0]; alloc0_src1_rdy = r1;
    alloc0_src2_tag = t2[6:0]; alloc0_src2_rdy = r2;
  endtask

  task automatic al1(input int idx, input int t1, input bit r1, input int t2, input bit r2);
    alloc1_valid = 1; alloc1_idx = idx[2:0];
    alloc1_src1_tag = t1[6:0]; alloc1_src1_rdy = r1;
    alloc1_src2_tag = t2[6:0]; alloc1_src2_rdy = r2;
  endtask

  // Monitor: every handshake consumes one expected index.
  always @(negedge clk) begin
    if (!reset && issue_valid && issue_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_issue: got idx %0d expected none", issue_idx);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("issue_order", 32'(issue_idx), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    reset = 1; issue_ready = 0; clr();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(entry_busy), 0);
    chk("rst_free", 32'(free_count), 8);
    chk("rst_valid", 32'(issue_valid), 0);
    chk("rst_idx", 32'(issue_idx), 0);
    @(posedge clk); #1; reset = 0;

    // single fully-ready entry
    al0(3, 'h01, 1, 'h02, 1); exp_q.push_back(3);
    cyc(); @(negedge clk);
    chk("t1_busy", 32'(entry_busy), 'h08);
    chk("t1_free", 32'(free_count), 7);
    chk("t1_not_yet", 32'(issue_valid), 0);
    cyc(); issue_ready = 1; @(negedge clk);
    chk("t1_valid", 32'(issue_valid), 1);
    chk("t1_idx", 32'(issue_idx), 3);
    chk("t1_busy2", 32'(entry_busy), 'h08);
    cyc(); @(negedge clk);
    chk("t1_busy_clr", 32'(entry_busy), 0);
    chk("t1_free8", 32'(free_count), 8);
    chk("t1_valid_off", 32'(issue_valid), 0);

    // dual alloc: slot 0 (idx 5) older than slot 1 (idx 1)
    al0(5, 'h03, 1, 'h04, 1); al1(1, 'h05, 1, 'h06, 1);
    exp_q.push_back(5); exp_q.push_back(1);
    cyc(); @(negedge clk);
    chk("t2_busy", 32'(entry_busy), 'h22);
    chk("t2_free", 32'(free_count), 6);
    cyc(); @(negedge clk);
    chk("t2_idx5", 32'(issue_idx), 5);
    cyc(); @(negedge clk);
    chk("t2_idx1", 32'(issue_idx), 1);
    chk("t2_busy1", 32'(entry_busy), 'h02);
    cyc(); @(negedge clk);
    chk("t2_valid_off", 32'(issue_valid), 0);

    // wait entry woken two cycles after alloc; wrong tag first
    al0(2, 'h11, 0, 'h22, 1); exp_q.push_back(2);
    cyc(); @(negedge clk);
    chk("t3_busy", 32'(entry_busy), 'h04);
    chk("t3_wait", 32'(issue_valid), 0);
    wb_valid = 1; wb_tag = 'h12;
    cyc(); @(negedge clk);
    chk("t3_wrong_tag", 32'(issue_valid), 0);
    wb_valid = 1; wb_tag = 'h11;
    cyc(); @(negedge clk);
    chk("t3_no_same_cyc", 32'(issue_valid), 0);
    cyc(); @(negedge clk);
    chk("t3_valid", 32'(issue_valid), 1);
    chk("t3_idx", 32'(issue_idx), 2);
    cyc(); @(negedge clk);
    chk("t3_busy_clr", 32'(entry_busy), 0);

    // alloc-cycle bypass
    al0(6, 'h11, 0, 'h22, 1); wb_valid = 1; wb_tag = 'h11; exp_q.push_back(6);
    cyc(); @(negedge clk);
    chk("t3b_busy", 32'(entry_busy), 'h40);
    chk("t3b_not_yet", 32'(issue_valid), 0);
    cyc(); @(negedge clk);
    chk("t3b_idx", 32'(issue_idx), 6);
    cyc(); @(negedge clk);
    chk("t3b_busy_clr", 32'(entry_busy), 0);

    // slot 1, src2 woken on alloc+1
    al1(4, 'h30, 1, 'h55, 0); exp_q.push_back(4);
    cyc(); wb_valid = 1; wb_tag = 'h55;
    cyc(); @(negedge clk);
    chk("t3c_no_same_cyc", 32'(issue_valid), 0);
    cyc(); @(negedge clk);
    chk("t3c_idx", 32'(issue_idx), 4);
    cyc(); @(negedge clk);
    chk("t3c_busy_clr", 32'(entry_busy), 0);

    // backpressure: idx 0 held for 3 stall cycles, then 4
    issue_ready = 0;
    al0(0, 'h07, 1, 'h08, 1); al1(4, 'h09, 1, 'h0a, 1);
    exp_q.push_back(0); exp_q.push_back(4);
    cyc(); @(negedge clk);
    chk("t4_free", 32'(free_count), 6);
    cyc(); @(negedge clk);
    chk("t4_hold1", 32'(issue_idx), 0);
    chk("t4_valid1", 32'(issue_valid), 1);
    cyc(); @(negedge clk);
    chk("t4_hold2", 32'(issue_idx), 0);
    cyc(); @(negedge clk);
    chk("t4_hold3", 32'(issue_idx), 0);
    cyc(); issue_ready = 1; @(negedge clk);
    cyc(); @(negedge clk);
    chk("t4_idx4", 32'(issue_idx), 4);
    cyc(); @(negedge clk);
    chk("t4_valid_off", 32'(issue_valid), 0);
`ifdef RS_ISSUE_PERF_EN
    chk("perf_stall", perf_stall, 3);
    chk("perf_issued", perf_issued, 8);
`endif

    // age across cycles: 2, then 7, then 3 must issue in allocation order
    issue_ready = 0;
    al0(2, 'h01, 1, 'h01, 1); exp_q.push_back(2);
    cyc(); al0(7, 'h01, 1, 'h01, 1); exp_q.push_back(7);
    cyc(); al0(3, 'h01, 1, 'h01, 1); exp_q.push_back(3);
    cyc(); issue_ready = 1; @(negedge clk);
    cyc(); @(negedge clk);
    chk("t6_idx7", 32'(issue_idx), 7);
    cyc(); @(negedge clk);
    cyc(); @(negedge clk);
    chk("t6_valid_off", 32'(issue_valid), 0);

    // fill all 8, flush, re-alloc
    issue_ready = 0;
    al0(0, 1, 1, 1, 1); al1(1, 1, 1, 1, 1); cyc();
    al0(2, 1, 1, 1, 1); al1(3, 1, 1, 1, 1); cyc();
    al0(4, 1, 1, 1, 1); al1(5, 1, 1, 1, 1); cyc();
    al0(6, 1, 1, 1, 1); al1(7, 1, 1, 1, 1); cyc();
    @(negedge clk);
    chk("t5_full", 32'(entry_busy), 'hff);
    chk("t5_free0", 32'(free_count), 0);
    chk("t5_valid", 32'(issue_valid), 1);
    flush = 1;
    cyc(); @(negedge clk);
    chk("t5_flush_busy", 32'(entry_busy), 0);
    chk("t5_flush_free", 32'(free_count), 8);
    chk("t5_flush_valid", 32'(issue_valid), 0);
    issue_ready = 1;
    al0(7, 1, 1, 1, 1); al1(2, 1, 1, 1, 1);
    exp_q.push_back(7); exp_q.push_back(2);
    cyc(); @(negedge clk);
    chk("t5_realloc_busy", 32'(entry_busy), 'h84);
    cyc(); @(negedge clk);
    chk("t5_idx7", 32'(issue_idx), 7);
    cyc(); @(negedge clk);
    chk("t5_idx2", 32'(issue_idx), 2);
    cyc(); @(negedge clk);
    chk("t5_end_free", 32'(free_count), 8);

    // asynchronous reset mid-operation
    issue_ready = 0;
    al0(1, 1, 1, 1, 1); al1(6, 'h40, 0, 1, 1);
    cyc(); cyc(); @(negedge clk);
    chk("t7_pre_valid", 32'(issue_valid), 1);
    #2 reset = 1;
    #1;
    chk("t7_async_busy", 32'(entry_busy), 0);
    chk("t7_async_free", 32'(free_count), 8);
    chk("t7_async_valid", 32'(issue_valid), 0);
    chk("t7_async_idx", 32'(issue_idx), 0);
`ifdef RS_ISSUE_PERF_EN
    chk("t7_perf_issued", perf_issued, 0);
    chk("t7_perf_stall", perf_stall, 0);
`endif
    @(posedge clk); #1; reset = 0;
    cyc(); @(negedge clk);
    chk("t7_post_busy", 32'(entry_busy), 0);
    chk("exp_q_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
